// File: rtl/uart_pkg.sv
// Shared encodings and helpers for the oversampling UART receiver.
package uart_pkg;
   localparam int OVERSAMPLE = 16;

   typedef enum logic [2:0] {
      PAR_NONE  = 3'd0,
      PAR_EVEN  = 3'd1,
      PAR_ODD   = 3'd2,
      PAR_MARK  = 3'd3,
      PAR_SPACE = 3'd4
   } parity_mode_t;

   typedef enum logic [2:0] {
      ST_IDLE, ST_START, ST_DATA, ST_PARITY, ST_STOP1, ST_STOP2, ST_BREAK_WAIT
   } rx_state_t;

   function automatic logic [3:0] clamp_bits(input logic [3:0] req, input int max_bits);
      if (req < 4'd5) return 4'd5;
      if (int'(req) > max_bits) return 4'(max_bits);
      return req;
   endfunction

   // Encodings 5..7 behave as no parity.
   function automatic parity_mode_t norm_parity(input logic [2:0] m);
      return (m > 3'd4) ? PAR_NONE : parity_mode_t'(m);
   endfunction
endpackage

// File: rtl/uart_sync_fifo.sv
// Show-ahead synchronous FIFO; a write while full succeeds only alongside a read.
module uart_sync_fifo #(
   parameter int WIDTH = 11,
   parameter int DEPTH = 16
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     wr_en,
   input  logic [WIDTH-1:0]         wr_data,
   input  logic                     rd_en,
   output logic [WIDTH-1:0]         rd_data,
   output logic [$clog2(DEPTH):0]   count,
   output logic                     full,
   output logic                     empty
);
   localparam int AW = $clog2(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_ptr, rd_ptr;
   logic             do_wr, do_rd;

   assign empty   = (count == '0);
   assign full    = (count == (AW+1)'(DEPTH));
   assign do_rd   = rd_en && !empty;
   assign do_wr   = wr_en && (!full || do_rd);
   assign rd_data = empty ? '0 : mem[rd_ptr];

   always_ff @(posedge clk) begin
      if (do_wr) mem[wr_ptr] <= wr_data;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_wr) wr_ptr <= wr_ptr + 1'b1;
         if (do_rd) rd_ptr <= rd_ptr + 1'b1;
         case ({do_wr, do_rd})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end
endmodule

// File: rtl/uart_rx_oversampled.sv
// 16x oversampling UART receiver with majority voting, parity/framing/break
// detection and a show-ahead receive FIFO.
module uart_rx_oversampled
   import uart_pkg::*;
#(
   parameter int MAX_DATA_BITS = 9,
   parameter int FIFO_DEPTH    = 16,
   parameter int DIV_WIDTH     = 16
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         rx,
   input  logic [DIV_WIDTH-1:0]         baud_div,
   input  logic [3:0]                   data_bits,
   input  logic [2:0]                   parity_mode,
   input  logic                         two_stop_bits,
   input  logic                         rd_en,
   output logic [MAX_DATA_BITS-1:0]     rd_data,
   output logic                         rd_perr,
   output logic                         rd_ferr,
   output logic                         rd_valid,
   output logic [$clog2(FIFO_DEPTH):0]  fifo_count,
   input  logic                         clr_overrun,
   output logic                         overrun,
   output logic                         break_det
);
   localparam int SW = $clog2(OVERSAMPLE);
   localparam int EW = MAX_DATA_BITS + 2;
   localparam logic [SW-1:0] TICK_A   = SW'(OVERSAMPLE/2 - 1);
   localparam logic [SW-1:0] TICK_B   = SW'(OVERSAMPLE/2);
   localparam logic [SW-1:0] TICK_C   = SW'(OVERSAMPLE/2 + 1);
   localparam logic [SW-1:0] TICK_END = SW'(OVERSAMPLE - 1);

   rx_state_t                state, state_next;
   logic                     rx_s1, rx_s2, rx_prev;
   logic [DIV_WIDTH-1:0]     div_q, tick_cnt;
   logic [3:0]               nbits_q, bit_cnt;
   parity_mode_t             par_q;
   logic                     two_q;
   logic [SW-1:0]            samp_cnt;
   logic                     s_a, s_b;
   logic [MAX_DATA_BITS-1:0] data_q;
   logic                     perr_q, par_bit, exp_par;
   logic                     push_pend, frame_end, brk, ovr_set, full, empty;
   logic [EW-1:0]            push_word, rd_word;
   logic                     tick, mid, bit_end, maj, start_det, last_bit;

   assign tick      = (tick_cnt == div_q);
   assign mid       = tick && (samp_cnt == TICK_C);
   assign bit_end   = tick && (samp_cnt == TICK_END);
   assign maj       = (s_a & s_b) | (s_a & rx_s2) | (s_b & rx_s2);
   assign start_det = (state == ST_IDLE) && rx_prev && !rx_s2;
   assign last_bit  = (bit_cnt == nbits_q - 4'd1);

   always_comb begin
      exp_par = 1'b0;
      case (par_q)
         PAR_EVEN: exp_par = ^data_q;
         PAR_ODD:  exp_par = ~^data_q;
         PAR_MARK: exp_par = 1'b1;
         default:  exp_par = 1'b0;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) state <= ST_IDLE;
      else     state <= state_next;
   end

   always_comb begin
      state_next = state;
      frame_end  = 1'b0;
      brk        = 1'b0;
      case (state)
         ST_IDLE:   if (start_det) state_next = ST_START;
         ST_START: begin
            if (mid && maj)   state_next = ST_IDLE;
            else if (bit_end) state_next = ST_DATA;
         end
         ST_DATA:   if (bit_end && last_bit)
                       state_next = (par_q != PAR_NONE) ? ST_PARITY : ST_STOP1;
         ST_PARITY: if (bit_end) state_next = ST_STOP1;
         ST_STOP1: begin
            // Stop bits resolve at mid-bit so a following start edge is not missed.
            if (mid) begin
               if (!maj && (data_q == '0) && !par_bit) begin
                  brk        = 1'b1;
                  state_next = ST_BREAK_WAIT;
               end else if (!(maj && two_q)) begin
                  frame_end  = 1'b1;
                  state_next = ST_IDLE;
               end
            end else if (bit_end) begin
               state_next = ST_STOP2;
            end
         end
         ST_STOP2: if (mid) begin
            frame_end  = 1'b1;
            state_next = ST_IDLE;
         end
         ST_BREAK_WAIT: if (rx_s2) state_next = ST_IDLE;
         default:   state_next = ST_IDLE;
      endcase
   end

   assign ovr_set = push_pend && full && !rd_en;

   always_ff @(posedge clk) begin
      if (rst) begin
         rx_s1     <= 1'b1;
         rx_s2     <= 1'b1;
         rx_prev   <= 1'b1;
         div_q     <= '0;
         nbits_q   <= '0;
         par_q     <= PAR_NONE;
         two_q     <= 1'b0;
         tick_cnt  <= '0;
         samp_cnt  <= '0;
         s_a       <= 1'b0;
         s_b       <= 1'b0;
         bit_cnt   <= '0;
         data_q    <= '0;
         perr_q    <= 1'b0;
         par_bit   <= 1'b0;
         push_pend <= 1'b0;
         push_word <= '0;
         break_det <= 1'b0;
         overrun   <= 1'b0;
      end else begin
         rx_s1     <= rx;
         rx_s2     <= rx_s1;
         rx_prev   <= rx_s2;
         push_pend <= frame_end;
         break_det <= brk;
         if (frame_end) push_word <= {data_q, perr_q, ~maj};
         if (ovr_set)          overrun <= 1'b1;
         else if (clr_overrun) overrun <= 1'b0;

         if (start_det) begin
            div_q    <= baud_div;
            nbits_q  <= clamp_bits(data_bits, MAX_DATA_BITS);
            par_q    <= norm_parity(parity_mode);
            two_q    <= two_stop_bits;
            tick_cnt <= '0;
            samp_cnt <= '0;
            bit_cnt  <= '0;
            data_q   <= '0;
            perr_q   <= 1'b0;
            par_bit  <= 1'b0;
         end else if (state == ST_IDLE || state == ST_BREAK_WAIT) begin
            tick_cnt <= '0;
            samp_cnt <= '0;
         end else begin
            tick_cnt <= tick ? '0 : tick_cnt + 1'b1;
            if (tick) begin
               samp_cnt <= samp_cnt + 1'b1;
               if (samp_cnt == TICK_A) s_a <= rx_s2;
               if (samp_cnt == TICK_B) s_b <= rx_s2;
            end
            if (mid && state == ST_DATA) begin
               for (int i = 0; i < MAX_DATA_BITS; i++)
                  if (bit_cnt == 4'(i)) data_q[i] <= maj;
            end
            if (mid && state == ST_PARITY) begin
               par_bit <= maj;
               perr_q  <= maj ^ exp_par;
            end
            if (bit_end && state == ST_DATA) bit_cnt <= bit_cnt + 4'd1;
         end
      end
   end

   uart_sync_fifo #(.WIDTH(EW), .DEPTH(FIFO_DEPTH)) u_fifo (
      .clk     (clk),
      .rst     (rst),
      .wr_en   (push_pend),
      .wr_data (push_word),
      .rd_en   (rd_en),
      .rd_data (rd_word),
      .count   (fifo_count),
      .full    (full),
      .empty   (empty)
   );

   assign rd_valid = !empty;
   assign rd_data  = rd_word[EW-1:2];
   assign rd_perr  = rd_word[1];
   assign rd_ferr  = rd_word[0];
endmodule

// File: tb/tb_uart_rx_oversampled.sv
// Directed bench for uart_rx_oversampled built with a 4-entry FIFO.
module tb_uart_rx_oversampled;
   logic        clk = 1'b0;
   logic        rst, rx, two_stop_bits, rd_en, clr_overrun;
   logic [15:0] baud_div;
   logic [3:0]  data_bits;
   logic [2:0]  parity_mode;
   logic [8:0]  rd_data;
   logic        rd_perr, rd_ferr, rd_valid, overrun, break_det;
   logic [2:0]  fifo_count;
   int          checks = 0;
   int          errors = 0;
   int          brk_cnt = 0;

   always #5 clk = ~clk;

   uart_rx_oversampled #(.MAX_DATA_BITS(9), .FIFO_DEPTH(4), .DIV_WIDTH(16)) dut (
      .clk(clk), .rst(rst), .rx(rx), .baud_div(baud_div), .data_bits(data_bits),
      .parity_mode(parity_mode), .two_stop_bits(two_stop_bits), .rd_en(rd_en),
      .rd_data(rd_data), .rd_perr(rd_perr), .rd_ferr(rd_ferr), .rd_valid(rd_valid),
      .fifo_count(fifo_count), .clr_overrun(clr_overrun), .overrun(overrun),
      .break_det(break_det)
   );

   always @(negedge clk) if (break_det === 1'b1) brk_cnt++;

   task automatic wait_clk();
      @(posedge clk);
      #1;
   endtask

   task automatic cfg(input int div, input int nb, input int par, input logic two);
      baud_div      = 16'(div);
      data_bits     = 4'(nb);
      parity_mode   = 3'(par);
      two_stop_bits = two;
   endtask

   // Line bit vector, LSB first: start, data, optional parity, stop(s).
   task automatic mk(input logic [8:0] d, input int nb, input logic pen, input logic pbit,
                     input logic s1, input logic two, input logic s2,
                     output logic [15:0] bits, output int len);
      bits = '1;
      bits[0] = 1'b0;
      len = 1;
      for (int i = 0; i < nb; i++) begin bits[len] = d[i]; len++; end
      if (pen) begin bits[len] = pbit; len++; end
      bits[len] = s1; len++;
      if (two) begin bits[len] = s2; len++; end
   endtask

   task automatic drive_frame(input logic [15:0] bits, input int len, input int pop_at,
                              input bit chk_rise);
      int per;
      per = 16 * (int'(baud_div) + 1);
      for (int c = 0; c < len * per; c++) begin
         rx    = bits[c / per];
         rd_en = (c == pop_at);
         wait_clk();
         if (chk_rise && c == 156) begin
            checks++;
            if (rd_valid !== 1'b0) begin errors++; $display("FAIL valid_early got %b want 0", rd_valid); end
         end
         if (chk_rise && c == 157) begin
            checks++;
            if (rd_valid !== 1'b1) begin errors++; $display("FAIL valid_rise got %b want 1", rd_valid); end
         end
      end
      rd_en = 1'b0;
   endtask

   task automatic idle(input int n);
      rx = 1'b1;
      repeat (n) wait_clk();
   endtask

   task automatic pop_entry(output logic [8:0] d, output logic pe, output logic fe);
      int t = 0;
      while (rd_valid !== 1'b1 && t < 400) begin wait_clk(); t++; end
      checks++;
      if (rd_valid !== 1'b1) begin errors++; $display("FAIL pop_timeout got %b want 1", rd_valid); end
      d = rd_data; pe = rd_perr; fe = rd_ferr;
      rd_en = 1'b1;
      wait_clk();
      rd_en = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1; rx = 1'b1; rd_en = 1'b0; clr_overrun = 1'b0;
      cfg(0, 8, 0, 1'b0);
      repeat (3) wait_clk();
      rst = 1'b0;
      wait_clk();
      checks++;
      if ({rd_valid, rd_perr, rd_ferr, overrun, break_det} !== 5'b0) begin
         errors++; $display("FAIL reset_flags got %b want 00000", {rd_valid, rd_perr, rd_ferr, overrun, break_det});
      end
      checks++;
      if (rd_data !== 9'h000) begin errors++; $display("FAIL reset_data got %h want 000", rd_data); end
      checks++;
      if (fifo_count !== 3'd0) begin errors++; $display("FAIL reset_count got %0d want 0", fifo_count); end
   endtask

   task automatic test_basic();
      logic [15:0] b; int n;
      cfg(0, 8, 0, 1'b0);
      mk(9'h0A5, 8, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, b, n);
      drive_frame(b, n, -1, 1'b1);
      idle(4);
      checks++;
      if ({rd_data, rd_perr, rd_ferr} !== {9'h0A5, 2'b00}) begin
         errors++; $display("FAIL basic_entry got %h/%b%b want 0a5/00", rd_data, rd_perr, rd_ferr);
      end
      checks++;
      if (fifo_count !== 3'd1) begin errors++; $display("FAIL basic_count got %0d want 1", fifo_count); end
      rd_en = 1'b1; wait_clk(); rd_en = 1'b0;
      checks++;
      if (rd_valid !== 1'b0) begin errors++; $display("FAIL basic_popped got %b want 0", rd_valid); end
      rd_en = 1'b1; wait_clk(); rd_en = 1'b0;
      checks++;
      if (fifo_count !== 3'd0) begin errors++; $display("FAIL empty_pop got %0d want 0", fifo_count); end
   endtask

   task automatic test_parity();
      logic [15:0] b; int n; logic [8:0] d; logic pe, fe;
      cfg(2, 9, 2, 1'b0);
      mk(9'h1FF, 9, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, b, n);
      drive_frame(b, n, -1, 1'b0); idle(4);
      pop_entry(d, pe, fe);
      checks++;
      if ({d, pe, fe} !== {9'h1FF, 2'b00}) begin errors++; $display("FAIL odd_p0 got %h/%b%b want 1ff/00", d, pe, fe); end
      mk(9'h1FF, 9, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, b, n);
      drive_frame(b, n, -1, 1'b0); idle(4);
      pop_entry(d, pe, fe);
      checks++;
      if ({d, pe, fe} !== {9'h1FF, 2'b10}) begin errors++; $display("FAIL odd_p1 got %h/%b%b want 1ff/10", d, pe, fe); end
      cfg(0, 8, 1, 1'b0);
      mk(9'h003, 8, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, b, n);
      drive_frame(b, n, -1, 1'b0); idle(4);
      pop_entry(d, pe, fe);
      checks++;
      if ({d, pe} !== {9'h003, 1'b1}) begin errors++; $display("FAIL even_err got %h/%b want 003/1", d, pe); end
      cfg(0, 8, 3, 1'b0);
      mk(9'h000, 8, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, b, n);
      drive_frame(b, n, -1, 1'b0); idle(4);
      pop_entry(d, pe, fe);
      checks++;
      if ({d, pe, fe} !== {9'h000, 2'b10}) begin errors++; $display("FAIL mark_err got %h/%b%b want 000/10", d, pe, fe); end
   endtask

   task automatic test_clamp();
      logic [15:0] b; int n; logic [8:0] d; logic pe, fe;
      cfg(0, 3, 0, 1'b0);
      mk(9'h015, 5, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, b, n);
      drive_frame(b, n, -1, 1'b0); idle(4);
      pop_entry(d, pe, fe);
      checks++;
      if (d !== 9'h015) begin errors++; $display("FAIL clamp_low got %h want 015", d); end
      cfg(0, 15, 0, 1'b0);
      mk(9'h1A5, 9, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, b, n);
      drive_frame(b, n, -1, 1'b0); idle(4);
      pop_entry(d, pe, fe);
      checks++;
      if (d !== 9'h1A5) begin errors++; $display("FAIL clamp_high got %h want 1a5", d); end
   endtask

   task automatic test_stop_bits();
      logic [15:0] b; int n; logic [8:0] d; logic pe, fe;
      cfg(0, 8, 0, 1'b1);
      mk(9'h03C, 8, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, b, n);
      drive_frame(b, n, -1, 1'b0); idle(4);
      pop_entry(d, pe, fe);
      checks++;
      if ({d, pe, fe} !== {9'h03C, 2'b01}) begin errors++; $display("FAIL stop2_err got %h/%b%b want 03c/01", d, pe, fe); end
      cfg(0, 8, 0, 1'b0);
      mk(9'h081, 8, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, b, n);
      drive_frame(b, n, -1, 1'b0); idle(4);
      pop_entry(d, pe, fe);
      checks++;
      if ({d, fe} !== {9'h081, 1'b1}) begin errors++; $display("FAIL stop1_err got %h/%b want 081/1", d, fe); end
   endtask

   task automatic test_glitch();
      int b0;
      cfg(0, 8, 0, 1'b0);
      b0 = brk_cnt;
      rx = 1'b0;
      repeat (4) wait_clk();
      idle(60);
      checks++;
      if (fifo_count !== 3'd0 || brk_cnt != b0) begin
         errors++; $display("FAIL glitch got count %0d brk %0d want 0 0", fifo_count, brk_cnt - b0);
      end
   endtask

   task automatic test_break();
      logic [15:0] b; int n; int b0; logic [8:0] d; logic pe, fe;
      cfg(0, 8, 0, 1'b0);
      b0 = brk_cnt;
      rx = 1'b0;
      repeat (320) wait_clk();
      idle(40);
      checks++;
      if (brk_cnt - b0 != 1) begin errors++; $display("FAIL break_pulses got %0d want 1", brk_cnt - b0); end
      checks++;
      if (fifo_count !== 3'd0) begin errors++; $display("FAIL break_push got %0d want 0", fifo_count); end
      mk(9'h055, 8, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, b, n);
      drive_frame(b, n, -1, 1'b0); idle(4);
      pop_entry(d, pe, fe);
      checks++;
      if ({d, pe, fe} !== {9'h055, 2'b00}) begin errors++; $display("FAIL after_break got %h/%b%b want 055/00", d, pe, fe); end
   endtask

   task automatic test_back_to_back();
      logic [15:0] b; int n; logic [8:0] d; logic pe, fe;
      cfg(0, 8, 0, 1'b0);
      mk(9'h00F, 8, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, b, n);
      drive_frame(b, n, -1, 1'b0);
      mk(9'h0F0, 8, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, b, n);
      drive_frame(b, n, -1, 1'b0);
      idle(4);
      pop_entry(d, pe, fe);
      checks++;
      if (d !== 9'h00F) begin errors++; $display("FAIL b2b_first got %h want 00f", d); end
      pop_entry(d, pe, fe);
      checks++;
      if (d !== 9'h0F0) begin errors++; $display("FAIL b2b_second got %h want 0f0", d); end
   endtask

   task automatic test_overrun();
      logic [15:0] b; int n; logic [8:0] d; logic pe, fe;
      logic [8:0] exp_q [4];
      cfg(0, 8, 0, 1'b0);
      for (int i = 0; i < 5; i++) begin
         mk(9'h011 + 9'(i), 8, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, b, n);
         drive_frame(b, n, -1, 1'b0);
      end
      idle(4);
      checks++;
      if (fifo_count !== 3'd4 || overrun !== 1'b1) begin
         errors++; $display("FAIL overrun_set got count %0d ovr %b want 4 1", fifo_count, overrun);
      end
      checks++;
      if (rd_data !== 9'h011) begin errors++; $display("FAIL overrun_head got %h want 011", rd_data); end
      clr_overrun = 1'b1; wait_clk(); clr_overrun = 1'b0;
      checks++;
      if (overrun !== 1'b0) begin errors++; $display("FAIL overrun_clr got %b want 0", overrun); end
      // Pop lands exactly in the push cycle of this frame while the FIFO is full.
      mk(9'h016, 8, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, b, n);
      drive_frame(b, n, 157, 1'b0);
      idle(4);
      checks++;
      if (fifo_count !== 3'd4 || overrun !== 1'b0) begin
         errors++; $display("FAIL full_pushpop got count %0d ovr %b want 4 0", fifo_count, overrun);
      end
      exp_q = '{9'h012, 9'h013, 9'h014, 9'h016};
      for (int i = 0; i < 4; i++) begin
         pop_entry(d, pe, fe);
         checks++;
         if (d !== exp_q[i]) begin errors++; $display("FAIL drain_%0d got %h want %h", i, d, exp_q[i]); end
      end
   endtask

   task automatic test_mid_reset();
      logic [15:0] b; int n; int b0;
      cfg(0, 8, 0, 1'b0);
      mk(9'h0C3, 8, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, b, n);
      drive_frame(b, n, -1, 1'b0);
      idle(4);
      b0 = brk_cnt;
      rx = 1'b0;
      repeat (60) wait_clk();
      rst = 1'b1; rx = 1'b1;
      repeat (2) wait_clk();
      checks++;
      if ({rd_valid, rd_perr, rd_ferr, overrun, break_det, fifo_count, rd_data} !== 17'b0) begin
         errors++; $display("FAIL midrst_outputs got %b%b%b%b%b cnt %0d data %h want all 0",
            rd_valid, rd_perr, rd_ferr, overrun, break_det, fifo_count, rd_data);
      end
      rst = 1'b0;
      idle(200);
      checks++;
      if (fifo_count !== 3'd0 || brk_cnt != b0) begin
         errors++; $display("FAIL midrst_discard got count %0d brk %0d want 0 0", fifo_count, brk_cnt - b0);
      end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_parity();
      test_clamp();
      test_stop_bits();
      test_glitch();
      test_break();
      test_back_to_back();
      test_overrun();
      test_mid_reset();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
